// File: rtl/demux_pkg.sv
// Shared types and helpers for the TDM demux sequencer.
// State encoding and channel geometry are fixed by the demux_2x4 datapath.
package demux_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  // Index of the lowest set bit; returns 0 for an empty mask.
  function automatic logic [SEL_W-1:0] lowest_idx(input logic [NCH-1:0] m);
    lowest_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = SEL_W'(i);
    end
  endfunction

endpackage

// File: rtl/demux_next_sel.sv
// Finds the next enabled channel strictly above sel; wrap flags the end of a frame.
// Purely combinational, no backpressure.
module demux_next_sel
  import demux_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] sel,
  output logic [SEL_W-1:0] next_sel,
  output logic             wrap
);

  always_comb begin
    next_sel = sel;
    wrap     = 1'b1;
    // Scan downwards so the lowest qualifying index wins.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(sel))) begin
        next_sel = SEL_W'(i);
        wrap     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/demux_tdm_ctrl.sv
// Round-robins accepted serial bits over the enabled demux channels, one registered bit per channel.
// Latency 1 from transfer to ch_valid; in_ready is high whenever a run is active.
module demux_tdm_ctrl
  import demux_pkg::*;
#(
  parameter int FRAMES = 0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [NCH-1:0]   en_mask,
  input  logic             d_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SEL_W-1:0] sel,
  output logic             demux_en,
  output logic [NCH-1:0]   ch_data,
  output logic [NCH-1:0]   ch_valid,
  output logic             busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_cnt
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [NCH-1:0]     mask_q, mask_d;
  logic [NCH-1:0]     ch_data_q, ch_data_d;
  logic [NCH-1:0]     ch_valid_q, ch_valid_d;
  logic               frame_done_q, frame_done_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   cnt_inc;
  logic [NCH-1:0]     new_mask;
  logic [SEL_W-1:0]   next_sel;
  logic               wrap;
  logic               xfer;

  demux_next_sel u_next_sel (
    .mask     (mask_q),
    .sel      (sel_q),
    .next_sel (next_sel),
    .wrap     (wrap)
  );

  assign busy       = (state_q != IDLE);
  assign in_ready   = busy;
  assign xfer       = in_valid & in_ready;
  assign demux_en   = xfer;
  assign sel        = sel_q;
  assign ch_data    = ch_data_q;
  assign ch_valid   = ch_valid_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    mask_d       = mask_q;
    ch_data_d    = ch_data_q;
    ch_valid_d   = '0;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    cnt_inc      = frame_cnt_q + CNT_W'(1);
    // An all-zero mask at a boundary keeps the current channel set.
    new_mask     = (en_mask != '0) ? en_mask : mask_q;

    case (state_q)
      IDLE: begin
        if (start && (en_mask != '0)) begin
          mask_d      = en_mask;
          sel_d       = lowest_idx(en_mask);
          frame_cnt_d = '0;
          state_d     = RUN;
        end
      end
      RUN, STOPPING: begin
        if (stop && (state_q == RUN)) state_d = STOPPING;
        if (xfer) begin
          ch_data_d[sel_q]  = d_in;
          ch_valid_d[sel_q] = 1'b1;
          if (wrap) begin
            mask_d       = new_mask;
            sel_d        = lowest_idx(new_mask);
            frame_done_d = 1'b1;
            frame_cnt_d  = cnt_inc;
            if ((state_q == STOPPING) || stop ||
                ((FRAMES != 0) && (cnt_inc == CNT_W'(FRAMES))))
              state_d = IDLE;
          end else begin
            sel_d = next_sel;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      mask_q       <= '0;
      ch_data_q    <= '0;
      ch_valid_q   <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      mask_q       <= mask_d;
      ch_data_q    <= ch_data_d;
      ch_valid_q   <= ch_valid_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_demux_tdm_ctrl.sv
// Directed + randomized bench for demux_tdm_ctrl against a frame-queue reference model.
module tb_demux_tdm_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stop, d_in, in_valid;
  logic [3:0] en_mask;

  logic        in_ready, demux_en, busy, frame_done;
  logic [1:0]  sel;
  logic [3:0]  ch_data, ch_valid;
  logic [15:0] frame_cnt;

  logic        in_ready2, demux_en2, busy2, frame_done2;
  logic [1:0]  sel2;
  logic [3:0]  ch_data2, ch_valid2;
  logic [15:0] frame_cnt2;

  demux_tdm_ctrl #(.FRAMES(0), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .en_mask(en_mask),
    .d_in(d_in), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
    .demux_en(demux_en), .ch_data(ch_data), .ch_valid(ch_valid), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  demux_tdm_ctrl #(.FRAMES(2), .CNT_W(16)) dut2 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .en_mask(en_mask),
    .d_in(d_in), .in_valid(in_valid), .in_ready(in_ready2), .sel(sel2),
    .demux_en(demux_en2), .ch_data(ch_data2), .ch_valid(ch_valid2), .busy(busy2),
    .frame_done(frame_done2), .frame_cnt(frame_cnt2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a run is a sequence of frames, each frame a queue of channels to visit.
  bit          m_busy, m_stopping;
  logic [3:0]  m_mask, m_data, m_valid;
  logic [1:0]  m_sel;
  logic [15:0] m_cnt;
  bit          m_done;
  int          m_q[$];

  int c2_xfer, c2_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_frame();
    m_q.delete();
    for (int i = 0; i < 4; i++) if (m_mask[i]) m_q.push_back(i);
    m_sel = 2'(m_q[0]);
  endtask

  task automatic model_step();
    int ch;
    m_valid = '0;
    m_done  = 1'b0;
    if (reset) begin
      m_busy = 0; m_stopping = 0; m_mask = '0; m_data = '0; m_sel = '0; m_cnt = '0;
      m_q.delete();
    end else if (!m_busy) begin
      if (start && en_mask != 0) begin
        m_busy = 1; m_stopping = 0; m_mask = en_mask; m_cnt = '0;
        build_frame();
      end
    end else begin
      if (stop) m_stopping = 1;
      if (in_valid) begin
        ch = m_q.pop_front();
        m_data[ch]  = d_in;
        m_valid[ch] = 1'b1;
        if (m_q.size() == 0) begin
          m_done = 1'b1;
          m_cnt  = m_cnt + 16'd1;
          if (en_mask != 0) m_mask = en_mask;
          build_frame();
          if (m_stopping) begin m_busy = 0; m_stopping = 0; end
        end else begin
          m_sel = 2'(m_q[0]);
        end
      end
    end
  endtask

  task automatic cycle();
    #1;
    chk("demux_en", {31'd0, demux_en}, {31'd0, in_valid & m_busy});
    c2_xfer += int'(demux_en2);
    model_step();
    @(posedge clk);
    #1;
    c2_done += int'(frame_done2);
    chk("sel",        {30'd0, sel},        {30'd0, m_sel});
    chk("ch_data",    {28'd0, ch_data},    {28'd0, m_data});
    chk("ch_valid",   {28'd0, ch_valid},   {28'd0, m_valid});
    chk("busy",       {31'd0, busy},       {31'd0, m_busy});
    chk("in_ready",   {31'd0, in_ready},   {31'd0, m_busy});
    chk("frame_done", {31'd0, frame_done}, {31'd0, m_done});
    chk("frame_cnt",  {16'd0, frame_cnt},  {16'd0, m_cnt});
  endtask

  task automatic do_reset();
    reset = 1; start = 0; stop = 0; in_valid = 0;
    cycle();
    reset = 0;
  endtask

  task automatic send(input logic b);
    d_in = b; in_valid = 1;
    cycle();
    in_valid = 0;
  endtask

  task automatic drain_with_stop();
    stop = 1; in_valid = 1;
    for (int i = 0; i < 8 && m_busy; i++) begin
      d_in = 1'($urandom_range(0, 1));
      cycle();
    end
    stop = 0; in_valid = 0;
    chk("drain_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1; start = 0; stop = 0; d_in = 0; in_valid = 0; en_mask = 4'b0000;
    c2_xfer = 0; c2_done = 0;
    m_busy = 0; m_stopping = 0; m_mask = '0; m_data = '0; m_valid = '0;
    m_sel = '0; m_cnt = '0; m_done = 0;
    cycle();
    do_reset();

    // 1: full mask, one frame
    en_mask = 4'b1111; start = 1; cycle(); start = 0;
    send(1); send(0); send(1); send(1);
    chk("t1_ch_data", {28'd0, ch_data}, 32'h0000000D);
    chk("t1_cnt", {16'd0, frame_cnt}, 32'd1);
    cycle();
    drain_with_stop();

    // 2: sparse mask, two frames
    do_reset();
    en_mask = 4'b1010; start = 1; cycle(); start = 0;
    send(1); send(1); send(0); send(1);
    chk("t2_ch_data", {28'd0, ch_data}, 32'h00000008);
    chk("t2_cnt", {16'd0, frame_cnt}, 32'd2);
    drain_with_stop();

    // 3: FRAMES=2 instance ends on its own
    do_reset();
    c2_xfer = 0; c2_done = 0;
    en_mask = 4'b0011; start = 1; cycle(); start = 0;
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      d_in = 1'($urandom_range(0, 1));
      cycle();
    end
    in_valid = 0;
    chk("t3_xfers", c2_xfer, 32'd4);
    chk("t3_done",  c2_done, 32'd2);
    chk("t3_busy",  {31'd0, busy2}, 32'd0);
    chk("t3_ready", {31'd0, in_ready2}, 32'd0);
    chk("t3_cnt",   {16'd0, frame_cnt2}, 32'd2);

    // 4: graceful stop mid-frame, then stop on a boundary
    do_reset();
    en_mask = 4'b1111; start = 1; cycle(); start = 0;
    send(1); send(0);
    stop = 1; send(1); stop = 0; send(0);
    chk("t4_idle", {31'd0, busy}, 32'd0);
    en_mask = 4'b0001; start = 1; cycle(); start = 0;
    stop = 1; send(1); stop = 0;
    chk("t4_bnd_idle", {31'd0, in_ready}, 32'd0);

    // 5: mask change mid-frame takes effect at the boundary
    do_reset();
    en_mask = 4'b1111; start = 1; cycle(); start = 0;
    send(1); send(1);
    en_mask = 4'b0001;
    send(0); send(1); send(1); send(0); send(1);
    chk("t5_sel", {30'd0, sel}, 32'd0);
    drain_with_stop();

    // Randomized traffic: stalls, mask churn, occasional stop/start
    do_reset();
    for (int i = 0; i < 300; i++) begin
      start    = ($urandom_range(0, 9) == 0);
      stop     = ($urandom_range(0, 24) == 0);
      in_valid = 1'($urandom_range(0, 1));
      d_in     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) en_mask = 4'($urandom_range(0, 15));
      cycle();
    end
    start = 0; stop = 0; in_valid = 0;

    // 6: reset mid-frame, then start with empty mask
    do_reset();
    en_mask = 4'b1111; start = 1; cycle(); start = 0;
    send(1); send(1);
    do_reset();
    chk("t6_ch_data", {28'd0, ch_data}, 32'd0);
    en_mask = 4'b0000; start = 1; cycle(); start = 0;
    cycle();
    chk("t6_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
